// File: rtl/bldc_pkg.sv
// Shared definitions for the BLDC hardware-in-the-loop blocks.
//
// Contents:
//   quad_state_t    - quadrature output state {A,B}: QS_00, QS_01, QS_11, QS_10
//   DIR_FWD/DIR_REV - direction encoding (1 = forward, 0 = reverse)
//   next_quad_state - one quadrature step from a given state in a given direction
package bldc_pkg;

    typedef enum logic [1:0] {
        QS_00 = 2'b00,
        QS_01 = 2'b01,
        QS_11 = 2'b11,
        QS_10 = 2'b10
    } quad_state_t;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    // Forward walks 00->01->11->10->00, reverse walks the same ring backwards.
    // Each transition flips exactly one of A/B, so the output is Gray coded.
    function automatic quad_state_t next_quad_state(input quad_state_t state, input logic dir);
        quad_state_t nxt;
        nxt = QS_00;
        if (dir == DIR_REV) begin
            case (state)
                QS_00:   nxt = QS_10;
                QS_10:   nxt = QS_11;
                QS_11:   nxt = QS_01;
                QS_01:   nxt = QS_00;
                default: nxt = QS_00;
            endcase
        end else begin
            case (state)
                QS_00:   nxt = QS_01;
                QS_01:   nxt = QS_11;
                QS_11:   nxt = QS_10;
                QS_10:   nxt = QS_00;
                default: nxt = QS_00;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/quad_step_timer.sv
// Step-interval timer for the quadrature encoder emulator.
//
// Counts 0..P-1 at the active period P and raises tick combinationally on
// the cycle the count sits at P-1; the count wraps to 0 on that same edge.
// A nonzero period below MIN_PERIOD is raised to MIN_PERIOD; a period of 0
// means stopped, in which case the count holds and tick stays low.
//
// Ports:
//   clk     in   1           clock
//   reset   in   1           asynchronous, active-high reset
//   enable  in   1           0 freezes the count and suppresses tick
//   period  in   DATA_WIDTH  active period in clk cycles (0 = stopped)
//   clear   in   1           restart the interval from 0 (new command applied)
//   tick    out  1           a step happens on this clock edge
module quad_step_timer #(
    parameter int DATA_WIDTH = 16,
    parameter int MIN_PERIOD = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] period,
    input  logic                  clear,
    output logic                  tick
);

    localparam logic [DATA_WIDTH-1:0] MIN_P = DATA_WIDTH'(MIN_PERIOD);

    logic [DATA_WIDTH-1:0] count_reg;
    logic [DATA_WIDTH-1:0] count_next;
    logic [DATA_WIDTH-1:0] eff_period;
    logic [DATA_WIDTH-1:0] terminal;
    logic                  running;

    assign running = (period != '0);

    always_comb begin
        eff_period = period;
        if (running && (period < MIN_P)) begin
            eff_period = MIN_P;
        end
    end

    assign terminal = eff_period - 1'b1;

    // The period only changes when the count is at 0 (wrap or clear), so
    // count never exceeds terminal; >= keeps the timer self-recovering anyway.
    assign tick = enable && running && (count_reg >= terminal);

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && running) begin
            if (tick) begin
                count_next = '0;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder transmitter used in place of a real motor encoder.
//
// Generates registered A/B/Z from a commanded step period and direction and
// keeps a modulo-CPR position count alongside them.
//
// Ports:
//   clk          in   1           clock
//   reset        in   1           asynchronous, active-high reset
//   enable       in   1           1 = run; 0 = freeze step timer and outputs
//   cmd_valid    in   1           command offer
//   cmd_ready    out  1           command slot (shadow register) free
//   cmd_period   in   DATA_WIDTH  clk cycles per quadrature edge; 0 = stop
//   cmd_dir      in   1           1 = forward, 0 = reverse
//   encoder_a    out  1           quadrature channel A
//   encoder_b    out  1           quadrature channel B
//   encoder_z    out  1           index: high while position==0 and {A,B}==00
//   position     out  POS_WIDTH   current count, 0..CPR-1
//   step_strobe  out  1           one-cycle pulse while A/B show a new value
module quad_encoder_emulator
    import bldc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CPR        = 64,
    parameter int POS_WIDTH  = 16,
    parameter int MIN_PERIOD = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_period,
    input  logic                  cmd_dir,
    output logic                  encoder_a,
    output logic                  encoder_b,
    output logic                  encoder_z,
    output logic [POS_WIDTH-1:0]  position,
    output logic                  step_strobe
);

    localparam logic [POS_WIDTH-1:0] CPR_LAST = POS_WIDTH'(CPR - 1);

    // Shadow (pending) command
    logic                  shadow_full_reg;
    logic [DATA_WIDTH-1:0] shadow_period_reg;
    logic                  shadow_dir_reg;

    // Active command
    logic [DATA_WIDTH-1:0] active_period_reg;
    logic                  active_dir_reg;

    // Output stage
    quad_state_t           quad_reg;
    quad_state_t           quad_next;
    logic [POS_WIDTH-1:0]  position_reg;
    logic [POS_WIDTH-1:0]  position_next;
    logic                  z_reg;
    logic                  z_next;
    logic                  strobe_reg;

    logic                  tick;
    logic                  running;
    logic                  transfer;
    logic                  apply_stopped;
    logic                  apply_running;
    logic                  apply_cmd;
    logic [1:0]            ab;

    assign running  = (active_period_reg != '0);
    assign transfer = cmd_valid && !shadow_full_reg;

    // From stopped a pending command goes live on the next enabled cycle.
    // While running it waits for the next step; that step still uses the old
    // direction because quad_next below is computed from active_dir_reg.
    // A command transferred in a step cycle is not yet in the shadow register,
    // so it naturally waits for the following step.
    assign apply_stopped = shadow_full_reg && !running && enable;
    assign apply_running = shadow_full_reg && tick;
    assign apply_cmd     = apply_stopped || apply_running;

    quad_step_timer #(
        .DATA_WIDTH (DATA_WIDTH),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .period (active_period_reg),
        .clear  (apply_cmd),
        .tick   (tick)
    );

    // Next quadrature state and position, only moving on a step.
    always_comb begin
        quad_next     = quad_reg;
        position_next = position_reg;
        if (tick) begin
            quad_next = next_quad_state(quad_reg, active_dir_reg);
            if (active_dir_reg == DIR_FWD) begin
                position_next = (position_reg == CPR_LAST) ? '0 : position_reg + 1'b1;
            end else begin
                position_next = (position_reg == '0) ? CPR_LAST : position_reg - 1'b1;
            end
        end
    end

    // Index follows the same register stage as A/B so Z can never glitch
    // relative to the channels.
    always_comb begin
        z_next = z_reg;
        if (tick) begin
            z_next = (position_next == '0) && (quad_next == QS_00);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_full_reg   <= 1'b0;
            shadow_period_reg <= '0;
            shadow_dir_reg    <= DIR_FWD;
        end else begin
            if (transfer) begin
                shadow_full_reg   <= 1'b1;
                shadow_period_reg <= cmd_period;
                shadow_dir_reg    <= cmd_dir;
            end else if (apply_cmd) begin
                shadow_full_reg   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_period_reg <= '0;
            active_dir_reg    <= DIR_FWD;
        end else if (apply_cmd) begin
            active_period_reg <= shadow_period_reg;
            active_dir_reg    <= shadow_dir_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quad_reg     <= QS_00;
            position_reg <= '0;
            z_reg        <= 1'b0;
            strobe_reg   <= 1'b0;
        end else begin
            quad_reg     <= quad_next;
            position_reg <= position_next;
            z_reg        <= z_next;
            strobe_reg   <= tick;
        end
    end

    assign ab          = quad_reg;
    assign encoder_a   = ab[1];
    assign encoder_b   = ab[0];
    assign encoder_z   = z_reg;
    assign position    = position_reg;
    assign step_strobe = strobe_reg;
    assign cmd_ready   = !shadow_full_reg;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Randomised and directed bench for quad_encoder_emulator (CPR = 8).
// A behavioural model tracks position as an integer modulo CPR and derives
// the expected A/B from position mod 4; every cycle the DUT is compared to it.
module tb_quad_encoder_emulator;

    localparam int DW    = 16;
    localparam int CPR   = 8;
    localparam int PW    = 16;
    localparam int MINP  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] cmd_period = '0;
    logic          cmd_dir = 1'b1;
    logic          encoder_a;
    logic          encoder_b;
    logic          encoder_z;
    logic [PW-1:0] position;
    logic          step_strobe;

    int total = 0;
    int bad   = 0;
    int strobe_seen = 0;

    // Model state
    int m_pos, m_elapsed, m_period, m_sh_period;
    bit m_dir, m_sh_dir, m_pending, m_z, m_strobe;

    quad_encoder_emulator #(
        .DATA_WIDTH (DW),
        .CPR        (CPR),
        .POS_WIDTH  (PW),
        .MIN_PERIOD (MINP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_period  (cmd_period),
        .cmd_dir     (cmd_dir),
        .encoder_a   (encoder_a),
        .encoder_b   (encoder_b),
        .encoder_z   (encoder_z),
        .position    (position),
        .step_strobe (step_strobe)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic int eff(input int p);
        if (p == 0) return 0;
        return (p < MINP) ? MINP : p;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_elapsed = 0; m_period = 0; m_sh_period = 0;
        m_dir = 1'b1; m_sh_dir = 1'b1; m_pending = 1'b0; m_z = 1'b0; m_strobe = 1'b0;
    endtask

    // One clock edge of the reference behaviour, using the inputs driven
    // before that edge.
    task automatic model_edge();
        bit fire, xfer, appl;
        fire = enable && (m_period != 0) && (m_elapsed == eff(m_period) - 1);
        xfer = cmd_valid && !m_pending;
        appl = m_pending && (fire || (m_period == 0 && enable));
        if (fire) begin
            m_pos = m_dir ? (m_pos + 1) % CPR : (m_pos + CPR - 1) % CPR;
            m_z   = (m_pos == 0);
        end
        m_strobe = fire;
        if (appl || fire) m_elapsed = 0;
        else if (enable && m_period != 0) m_elapsed++;
        if (appl) begin
            m_period = m_sh_period;
            m_dir    = m_sh_dir;
        end
        if (xfer) begin
            m_pending = 1'b1; m_sh_period = int'(cmd_period); m_sh_dir = cmd_dir;
        end else if (appl) begin
            m_pending = 1'b0;
        end
    endtask

    task automatic check_all();
        int q;
        q = m_pos % 4;
        check_val("enc_a",    encoder_a,   (q == 2 || q == 3) ? 1 : 0);
        check_val("enc_b",    encoder_b,   (q == 1 || q == 2) ? 1 : 0);
        check_val("enc_z",    encoder_z,   m_z);
        check_val("position", position,    m_pos);
        check_val("strobe",   step_strobe, m_strobe);
        check_val("ready",    cmd_ready,   !m_pending);
    endtask

    // Inputs are set by the caller at the falling edge before this is called.
    task automatic step_cycle();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        check_all();
        if (step_strobe) strobe_seen++;
    endtask

    task automatic send_cmd(input int p, input bit d);
        int n;
        n = 0;
        while (m_pending && n < 200) begin step_cycle(); n++; end
        cmd_valid = 1'b1; cmd_period = DW'(p); cmd_dir = d;
        step_cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_applied(input string tag);
        int n;
        n = 0;
        while (m_pending && n < 200) begin step_cycle(); n++; end
        check_val(tag, cmd_ready, 1);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        cmd_valid = 1'b0;
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        int n, p0, zcnt, c, hold;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_a", encoder_a, 0);
        check_val("rst_b", encoder_b, 0);
        check_val("rst_z", encoder_z, 0);
        check_val("rst_pos", position, 0);
        check_val("rst_ready", cmd_ready, 1);
        check_val("rst_strobe", step_strobe, 0);
        reset = 1'b0;

        // Forward P=4 from stopped: edges at +4,+8,+12,+16 after apply
        send_cmd(4, 1'b1);
        step_cycle();
        strobe_seen = 0;
        repeat (16) step_cycle();
        check_val("fwd_edges", strobe_seen, 4);
        check_val("fwd_pos", position, 4);
        check_val("fwd_ab", {encoder_a, encoder_b}, 0);

        // Forward wrap 7 -> 0, Z high for exactly one interval
        repeat (16) step_cycle();
        check_val("wrap_pos", position, 0);
        check_val("wrap_z", encoder_z, 1);
        zcnt = 1;
        repeat (7) begin step_cycle(); if (encoder_z) zcnt++; end
        check_val("z_width", zcnt, 4);

        // Reversal offered two cycles before an edge
        n = 0;
        while (m_elapsed != 1 && n < 50) begin step_cycle(); n++; end
        p0 = m_pos;
        cmd_valid = 1'b1; cmd_period = DW'(4); cmd_dir = 1'b0;
        step_cycle();
        cmd_valid = 1'b0;
        check_val("rev_ready_low", cmd_ready, 0);
        step_cycle();
        check_val("rev_pos_hold", position, p0);
        step_cycle();
        check_val("rev_first_fwd", position, (p0 + 1) % CPR);
        check_val("rev_ready_back", cmd_ready, 1);
        repeat (4) step_cycle();
        check_val("rev_second", position, p0);

        // Reverse wrap 0 -> CPR-1
        n = 0;
        while (position != 0 && n < 100) begin step_cycle(); n++; end
        check_val("rev_zero_z", encoder_z, 1);
        repeat (4) step_cycle();
        check_val("rev_wrap_pos", position, CPR - 1);
        check_val("rev_wrap_z", encoder_z, 0);

        // Clamp: period 1 behaves as 2
        send_cmd(1, 1'b1);
        wait_applied("clamp_applied");
        strobe_seen = 0;
        repeat (20) step_cycle();
        check_val("clamp_edges", strobe_seen, 10);

        // Stop: outputs hold for 100 cycles
        send_cmd(0, 1'b1);
        wait_applied("stop_applied");
        hold = int'(position);
        strobe_seen = 0;
        repeat (100) step_cycle();
        check_val("stop_edges", strobe_seen, 0);
        check_val("stop_pos", position, hold);

        // enable low for 10 cycles mid-interval delays the edge by 10
        send_cmd(4, 1'b1);
        wait_applied("en_applied");
        c = 0;
        strobe_seen = 0;
        while (strobe_seen == 0 && c < 100) begin
            enable = !(c >= 2 && c < 12);
            step_cycle();
            c++;
        end
        enable = 1'b1;
        check_val("enable_delay", c, 14);

        // Reset mid-run with a command pending
        send_cmd(5, 1'b0);
        check_val("pend_ready", cmd_ready, 0);
        do_reset();
        check_val("mrst_pos", position, 0);
        check_val("mrst_ab", {encoder_a, encoder_b}, 0);
        check_val("mrst_z", encoder_z, 0);
        check_val("mrst_ready", cmd_ready, 1);
        strobe_seen = 0;
        repeat (20) step_cycle();
        check_val("mrst_quiet", strobe_seen, 0);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            enable     = ($urandom_range(0, 9) != 0);
            cmd_valid  = ($urandom_range(0, 7) == 0);
            cmd_period = DW'($urandom_range(0, 6));
            cmd_dir    = 1'($urandom_range(0, 1));
            step_cycle();
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
        end
        cmd_valid = 1'b0;
        enable = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
